// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the master bridge and its neighbours:
// transfer-type encoding, HSIZE/HBURST/HPROT constants, the pipeline stage
// record carried through the master's address and data stages, and the
// alignment rule used when the optional alignment check is compiled in.
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Widest address/data the stage record can carry.
    localparam int STAGE_ADDR_W = 32;
    localparam int STAGE_DATA_W = 32;

    typedef struct packed {
        logic                    vld;
        logic                    write;
        logic [STAGE_ADDR_W-1:0] addr;
        logic [2:0]              size;
        logic [STAGE_DATA_W-1:0] wdata;
        logic                    misalign;
    } stage_t;

    // Error-response tracking: ERR1 is the registered first error cycle,
    // RETRY re-presents the address-phase command cancelled during ERR1.
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ERR1   = 2'd1,
        RETRY  = 2'd2
    } err_state_e;

    function automatic logic is_misaligned(input logic [STAGE_ADDR_W-1:0] addr,
                                           input logic [2:0]              size);
        logic [STAGE_ADDR_W-1:0] mask;
        mask = (STAGE_ADDR_W'(1) << size) - STAGE_ADDR_W'(1);
        return (addr & mask) != '0;
    endfunction

endpackage

// File: rtl/ahb3lite_master.sv
// ---------------------------------------------------------------------------
// ahb3lite_master
// Single-master AHB-Lite bridge. Local engines hand in single-beat read/write
// commands on a valid/ready port; the bridge drives pipelined address and
// data phases, honours HREADY wait states and two-cycle HRESP errors, and
// returns exactly one in-order response pulse per accepted command.
//
// Ports
//   HCLK, HRESET              bus clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready combinational on HREADY)
//   cmd_write/addr/size/wdata command fields (size uses the HSIZE encoding)
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response, no backpressure
//   HSEL HADDR HTRANS HWRITE HSIZE HBURST HPROT HWDATA  AHB-Lite master outputs
//   HREADY HRDATA HRESP       AHB-Lite fabric inputs
//
// Build option
//   AHBM_ALIGN_CHECK_EN  when defined, misaligned commands never reach the bus;
//                        they ride the pipeline as IDLE slots and complete
//                        with rsp_err=1 in order.
// ---------------------------------------------------------------------------
module ahb3lite_master
    import ahb_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 32,
    parameter logic [3:0]  HPROT_VAL = HPROT_DEFAULT
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HRESP
);

    err_state_e        state, state_nxt;
    stage_t            a_stage;        // address phase
    stage_t            cmd_stage;      // incoming command as a stage record
    logic              d_vld;          // data phase
    logic              d_write;
    logic              d_misalign;
    logic [DATA_W-1:0] d_wdata;
    logic              accept;
    logic              a_on_bus;

    assign cmd_ready = HREADY && (state == NORMAL) && !HRESET;
    assign accept    = cmd_valid && cmd_ready;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cmd_stage       = '0;
        cmd_stage.vld   = 1'b1;
        cmd_stage.write = cmd_write;
        cmd_stage.addr  = STAGE_ADDR_W'(cmd_addr);
        cmd_stage.size  = cmd_size;
        cmd_stage.wdata = cmd_wdata;
`ifdef AHBM_ALIGN_CHECK_EN
        cmd_stage.misalign = is_misaligned(STAGE_ADDR_W'(cmd_addr), cmd_size);
`else
        cmd_stage.misalign = 1'b0;
`endif
    end

    // During the second error cycle the pending address phase is withdrawn
    // (IDLE); misaligned slots never appear on the bus at all.
    assign a_on_bus = a_stage.vld && !a_stage.misalign && (state != ERR1);
    assign HTRANS   = a_on_bus ? NONSEQ : IDLE;
    assign HSEL     = a_on_bus;
    assign HADDR    = a_stage.addr[ADDR_W-1:0];
    assign HWRITE   = a_stage.write;
    assign HSIZE    = a_stage.size;
    assign HBURST   = HBURST_SINGLE;
    assign HPROT    = HPROT_VAL;
    assign HWDATA   = d_wdata;

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: if (d_vld && !d_misalign && !HREADY && HRESP) state_nxt = ERR1;
            ERR1:   if (HREADY) state_nxt = a_stage.vld ? RETRY : NORMAL;
            RETRY:  if (HREADY) state_nxt = NORMAL;
            default:            state_nxt = NORMAL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= NORMAL;
            a_stage    <= '0;
            d_vld      <= 1'b0;
            d_write    <= 1'b0;
            d_misalign <= 1'b0;
            d_wdata    <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;

            // Data-phase completion. In ERR1 the completion is an error even
            // if HRESP was dropped early; an unannounced HRESP=1 with HREADY=1
            // is also reported as an error.
            if (HREADY && d_vld) begin
                rsp_valid <= 1'b1;
                if (d_misalign || (state == ERR1) || HRESP) begin
                    rsp_err <= 1'b1;
                end else if (!d_write) begin
                    rsp_rdata <= HRDATA;
                end
            end

            if (HREADY) begin
                if (state == ERR1) begin
                    // The cancelled address-phase command stays in A for retry.
                    d_vld <= 1'b0;
                end else begin
                    d_vld      <= a_stage.vld;
                    d_write    <= a_stage.write;
                    d_misalign <= a_stage.misalign;
                    d_wdata    <= a_stage.wdata;
                    a_stage    <= accept ? cmd_stage : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_master
// Drives ahb3lite_master with command sequences, plays an AHB-Lite subordinate
// with programmable wait states and two-cycle error responses, and compares
// every response and bus transfer against an in-order reference model.
// ---------------------------------------------------------------------------
module tb_ahb3lite_master;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HRESP;

    ahb3lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } rsp_t;

    cmd_t        pend[$];       // commands waiting to be offered
    rsp_t        exp_rsp[$];    // expected responses, in command order
    cmd_t        exp_bus[$];    // expected bus transfers, in order
    int          wait_plan[$];  // forced wait counts for upcoming data phases
    logic [31:0] ref_mem [0:16383];
    logic [31:0] slv_mem [0:16383];
    bit          err_map [logic [15:0]];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int max_wait      = 0;
    int gap_pct       = 0;
    int stall_left    = 0;
    bit check_latency = 0;

    logic [15:0] watch_addr = 16'hFFFF;
    int          watch_cnt  = 0;
    int          watch_xfer = 0;

    // subordinate data-phase state
    bit   dp_active = 0;
    cmd_t dp;
    bit   dp_err  = 0;
    bit   dp_err2 = 0;
    int   dp_wait = 0;

    logic        prev_hready = 1'b1;
    logic        prev_hresp  = 1'b0;
    logic [1:0]  prev_htrans = 2'b00;
    logic [15:0] prev_haddr  = '0;
    logic        prev_hwrite = 1'b0;
    logic [2:0]  prev_hsize  = '0;

    function automatic bit slave_err(input logic [15:0] a);
        return err_map.exists(a) || (a[15:12] == 4'hE);
    endfunction

    function automatic bit model_misaligned(input logic [15:0] a, input logic [2:0] s);
`ifdef AHBM_ALIGN_CHECK_EN
        int unsigned lowbits;
        lowbits = 32'(a) % (32'd1 << s);
        return lowbits != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: every accepted command yields exactly one response,
    // in acceptance order; memory effects are applied in the same order.
    task automatic model_accept(input cmd_t c);
        rsp_t r;
        r.write   = c.write;
        r.addr    = c.addr;
        r.acc_cyc = cyc;
        r.rdata   = '0;
        r.err     = 1'b0;
        if (model_misaligned(c.addr, c.size)) begin
            r.err = 1'b1;
        end else begin
            exp_bus.push_back(c);
            if (slave_err(c.addr)) r.err = 1'b1;
            else if (c.write)      ref_mem[c.addr[15:2]] = c.wdata;
            else                   r.rdata = ref_mem[c.addr[15:2]];
        end
        exp_rsp.push_back(r);
    endtask

    // One bus cycle, entered and left at the falling edge.
    task automatic tick();
        logic hr, hp;
        bit   err2_now;
        rsp_t r;
        cmd_t e;
        cmd_t c;
        err2_now = 0;
        if (HRESET)                              begin hr = 1'b1; hp = 1'b0; end
        else if (stall_left > 0)                 begin hr = 1'b0; hp = 1'b0; end
        else if (dp_active && dp_wait > 0)       begin hr = 1'b0; hp = 1'b0; end
        else if (dp_active && dp_err && !dp_err2) begin hr = 1'b0; hp = 1'b1; end
        else if (dp_active && dp_err)            begin hr = 1'b1; hp = 1'b1; err2_now = 1; end
        else                                     begin hr = 1'b1; hp = 1'b0; end
        HREADY = hr;
        HRESP  = hp;
        HRDATA = (dp_active && !dp.write && !dp_err) ? slv_mem[dp.addr[15:2]] : $urandom;

        if (!HRESET && pend.size() > 0 && $urandom_range(99) >= gap_pct) begin
            c         = pend[0];
            cmd_valid = 1'b1;
            cmd_write = c.write;
            cmd_addr  = c.addr;
            cmd_size  = c.size;
            cmd_wdata = c.wdata;
        end else begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 16'($urandom);
            cmd_size  = 3'($urandom);
            cmd_wdata = $urandom;
        end
        #1;

        if (rsp_valid) begin
            checks++;
            if (exp_rsp.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0b, required no response", rsp_err);
            end else begin
                r = exp_rsp.pop_front();
                if (rsp_err !== r.err || (!r.write && rsp_rdata !== r.rdata)) begin
                    failures++;
                    $display("FAIL rsp@%h: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             r.addr, rsp_err, rsp_rdata, r.err, r.rdata);
                end
                if (check_latency) begin
                    checks++;
                    if (cyc - r.acc_cyc !== 3) begin
                        failures++;
                        $display("FAIL latency@%h: got %0d cycles, required 3", r.addr, cyc - r.acc_cyc);
                    end
                end
            end
        end

        if (HRESET) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_reset: got %0b, required 0", cmd_ready);
            end
            exp_rsp.delete();
            exp_bus.delete();
            dp_active   = 0;
            stall_left  = 0;
            prev_hready = 1'b1;
        end else begin
            checks++;
            if (HSEL !== (HTRANS == 2'b10) || HBURST !== 3'b000 || HPROT !== 4'b0011) begin
                failures++;
                $display("FAIL bus_consts: got HSEL=%0b HBURST=%0d HPROT=%h HTRANS=%0d, required HSEL=(HTRANS==NONSEQ) HBURST=0 HPROT=3",
                         HSEL, HBURST, HPROT, HTRANS);
            end
            if (!hr) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ready_in_wait: got %0b, required 0", cmd_ready);
                end
            end
            if (prev_hready === 1'b0 && prev_hresp === 1'b0 && prev_htrans == 2'b10) begin
                checks++;
                if ({HTRANS, HADDR, HWRITE, HSIZE} !== {prev_htrans, prev_haddr, prev_hwrite, prev_hsize}) begin
                    failures++;
                    $display("FAIL addr_stable: got HTRANS=%0d HADDR=%h, required HTRANS=%0d HADDR=%h",
                             HTRANS, HADDR, prev_htrans, prev_haddr);
                end
            end
            if (err2_now) begin
                checks++;
                if (HTRANS !== 2'b00) begin
                    failures++;
                    $display("FAIL htrans_err2: got %0d, required 0 (IDLE)", HTRANS);
                end
            end
            if (HTRANS == 2'b10 && HADDR == watch_addr) begin
                watch_cnt++;
                if (hr) watch_xfer++;
            end

            if (cmd_valid && cmd_ready) model_accept(pend.pop_front());

            if (hr) begin
                if (dp_active) begin
                    if (dp.write && !dp_err) begin
                        checks++;
                        if (HWDATA !== dp.wdata) begin
                            failures++;
                            $display("FAIL hwdata@%h: got %h, required %h", dp.addr, HWDATA, dp.wdata);
                        end
                        slv_mem[dp.addr[15:2]] = HWDATA;
                    end
                    dp_active = 0;
                end
                if (HTRANS == 2'b10) begin
                    checks++;
                    if (exp_bus.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_xfer: got NONSEQ at %h, required none", HADDR);
                    end else begin
                        e = exp_bus.pop_front();
                        if ({HADDR, HWRITE, HSIZE} !== {e.addr, e.write, e.size}) begin
                            failures++;
                            $display("FAIL xfer: got addr=%h wr=%0b size=%0d, required addr=%h wr=%0b size=%0d",
                                     HADDR, HWRITE, HSIZE, e.addr, e.write, e.size);
                        end
                        dp_active = 1;
                        dp        = e;
                        dp_err    = slave_err(HADDR);
                        dp_err2   = 0;
                        dp_wait   = (wait_plan.size() > 0) ? wait_plan.pop_front()
                                                           : int'($urandom_range(max_wait));
                    end
                end
            end else begin
                if (stall_left > 0)                stall_left--;
                else if (dp_active && dp_wait > 0) dp_wait--;
                else if (dp_active && dp_err)      dp_err2 = 1;
            end

            prev_hready = hr;
            prev_hresp  = hp;
            prev_htrans = HTRANS;
            prev_haddr  = HADDR;
            prev_hwrite = HWRITE;
            prev_hsize  = HSIZE;
        end
        cyc++;
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic push_cmd(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata);
        cmd_t c;
        c.write = wr; c.addr = addr; c.size = size; c.wdata = wdata;
        pend.push_back(c);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pend.size() > 0 || exp_rsp.size() > 0 || dp_active) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 1000 || exp_bus.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d responses and %0d transfers outstanding, required 0",
                     name, exp_rsp.size(), exp_bus.size());
            exp_rsp.delete();
            exp_bus.delete();
            pend.delete();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({HTRANS, HSEL, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_values: got HTRANS=%0d HSEL=%0b HADDR=%h HWRITE=%0b HSIZE=%0d HWDATA=%h rsp=%0b/%0b/%h, required all 0",
                     HTRANS, HSEL, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_err, rsp_rdata);
        end
        HRESET = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %0b, required 1", cmd_ready);
        end
        tick();
    endtask

    task automatic test_write_read();
        check_latency = 1;
        push_cmd(1'b1, 16'h0010, 3'd2, 32'hDEADBEEF);
        push_cmd(1'b0, 16'h0010, 3'd2, 32'h0);
        drain("write_read");
        check_latency = 0;
    endtask

    task automatic test_wait_states();
        watch_addr = 16'h0008; watch_cnt = 0; watch_xfer = 0;
        wait_plan = '{0, 2, 0, 0};
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 16'(i * 4), 3'd2, 32'h0);
        drain("wait_states");
        checks++;
        if (watch_cnt !== 3 || watch_xfer !== 1) begin
            failures++;
            $display("FAIL haddr_hold: got %0d cycles/%0d transfers at 0008, required 3/1", watch_cnt, watch_xfer);
        end
    endtask

    task automatic test_error();
        err_map[16'h0020] = 1'b1;
        watch_addr = 16'h0024; watch_cnt = 0; watch_xfer = 0;
        push_cmd(1'b1, 16'h0020, 3'd2, 32'h12345678);
        push_cmd(1'b0, 16'h0024, 3'd2, 32'h0);
        drain("error");
        checks++;
        if (watch_xfer !== 1) begin
            failures++;
            $display("FAIL retry_once: got %0d transfers at 0024, required 1", watch_xfer);
        end
    endtask

    task automatic test_reset_inflight();
        push_cmd(1'b0, 16'h0030, 3'd2, 32'h0);
        push_cmd(1'b0, 16'h0034, 3'd2, 32'h0);
        push_cmd(1'b0, 16'h0038, 3'd2, 32'h0);
        tick();
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        pend.delete();
        checks++;
        if (HTRANS !== 2'b00 || HSEL !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush: got HTRANS=%0d HSEL=%0b rsp_valid=%0b, required 0/0/0", HTRANS, HSEL, rsp_valid);
        end
        repeat (4) tick();
        push_cmd(1'b0, 16'h0030, 3'd2, 32'h0);
        drain("after_reset");
    endtask

    task automatic test_stall_accept();
        watch_addr = 16'h0040; watch_cnt = 0; watch_xfer = 0;
        stall_left = 5;
        push_cmd(1'b1, 16'h0040, 3'd2, 32'hA5A5_0F0F);
        repeat (5) tick();
        checks++;
        if (pend.size() !== 1) begin
            failures++;
            $display("FAIL stall_accept: got %0d pending, required 1", pend.size());
        end
        tick();
        checks++;
        if (pend.size() !== 0) begin
            failures++;
            $display("FAIL stall_release: got %0d pending, required 0", pend.size());
        end
        push_cmd(1'b0, 16'h0040, 3'd2, 32'h0);
        drain("stall");
        checks++;
        if (watch_xfer !== 2) begin
            failures++;
            $display("FAIL stall_once: got %0d transfers at 0040, required 2 (write+read)", watch_xfer);
        end
    endtask

    task automatic test_size();
        push_cmd(1'b0, 16'h0041, 3'd0, 32'h0);
        push_cmd(1'b0, 16'h0042, 3'd1, 32'h0);
        push_cmd(1'b0, 16'h0048, 3'd3, 32'h0);
        drain("size");
    endtask

    task automatic test_align();
        watch_addr = 16'h0002; watch_cnt = 0; watch_xfer = 0;
        push_cmd(1'b0, 16'h0050, 3'd2, 32'h0);
        push_cmd(1'b1, 16'h0002, 3'd2, 32'hCAFEF00D);
        push_cmd(1'b1, 16'h0054, 3'd2, 32'h0BADCAFE);
        push_cmd(1'b0, 16'h0000, 3'd2, 32'h0);
        push_cmd(1'b0, 16'h0054, 3'd2, 32'h0);
        drain("align");
        checks++;
`ifdef AHBM_ALIGN_CHECK_EN
        if (watch_cnt !== 0) begin
            failures++;
            $display("FAIL align_no_bus: got %0d NONSEQ cycles at 0002, required 0", watch_cnt);
        end
`else
        if (watch_xfer !== 1) begin
            failures++;
            $display("FAIL align_passthru: got %0d transfers at 0002, required 1", watch_xfer);
        end
`endif
    endtask

    task automatic test_back_to_back();
        check_latency = 1;
        for (int i = 0; i < 8; i++)
            push_cmd(1'(i % 2), 16'h0080 + 16'((i / 2) * 4), 3'd2, $urandom);
        drain("back_to_back");
        check_latency = 0;
    endtask

    task automatic test_random();
        max_wait = 2;
        gap_pct  = 30;
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            if ($urandom_range(9) == 0) a = {4'hE, 10'($urandom), 2'b00};
            else                        a = {8'h01, 6'($urandom), 2'b00};
            push_cmd(1'($urandom), a, 3'd2, $urandom);
        end
        drain("random");
        max_wait = 0;
        gap_pct  = 0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            logic [31:0] v;
            v = $urandom;
            ref_mem[i] = v;
            slv_mem[i] = v;
        end
        HRESET    = 1'b1;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        @(negedge HCLK);

        test_reset();
        test_write_read();
        test_wait_states();
        test_error();
        test_reset_inflight();
        test_stall_accept();
        test_size();
        test_align();
        test_back_to_back();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
